uart_cmd_parser_p: RTL and testbench

//  Parametrised UART command receiver and frame parser for host control of the local-dimming pipeline.
//  - Deserialises 8N1 bytes from uart_rx.
//  - Parses frames of the form HEADER, CMD, LEN, PAYLOAD[LEN], CHK.
//  - Presents cmdcode and payload with a one-cycle valid strobe.

---
 rtl/uart_cmd_parser_p.sv | 219 +++++++++++++++++++++
 tb/tb_uart_cmd_parser_p.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser_p.sv
// UART command receiver and frame parser.
// An 8N1 byte receiver feeds a frame parser for HEADER, CMD, LEN, PAYLOAD[LEN], CHK.
// A good frame is latched onto the outputs with a one-cycle cmd_valid strobe.
// An aborted frame raises a one-cycle cmd_err strobe with a cause in err_code.
// Handshake: cmd_valid and cmd_err are single-cycle strobes with no back-pressure.
// On a cmd_valid pulse, para_list, cmdcode, cmd_len and check hold the new frame.
// On a cmd_err pulse, err_code holds the cause and the other outputs keep the last good frame.
module uart_cmd_parser_p #(
    parameter int          CLK_FREQ_HZ    = 50_000_000,
    parameter int          BAUD           = 115200,
    parameter int          MAX_PARA_BYTES = 4,
    parameter logic [7:0]  HEADER         = 8'h55,
    parameter int          CHK_MODE       = 0,
    parameter int          TIMEOUT_BITS   = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          uart_rx,
    output logic [8*MAX_PARA_BYTES-1:0]   para_list,
    output logic [7:0]                    cmdcode,
    output logic [7:0]                    cmd_len,
    output logic [7:0]                    check,
    output logic                          cmd_valid,
    output logic                          cmd_err,
    output logic [1:0]                    err_code
);

    localparam int              DIV      = CLK_FREQ_HZ / BAUD;
    localparam int              CW       = $clog2(DIV + 1);
    localparam logic [CW-1:0]   DIV_M1   = CW'(DIV - 1);
    localparam logic [CW-1:0]   HALF_M1  = CW'(DIV / 2 - 1);
    localparam logic [31:0]     TO_LIMIT = 32'(TIMEOUT_BITS * DIV);
    localparam logic [7:0]      MAX_B    = 8'(MAX_PARA_BYTES);
    localparam int              IDXW     = (MAX_PARA_BYTES > 1) ? $clog2(MAX_PARA_BYTES) : 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_PARA, S_CHK} p_state_t;

    rx_state_t         rx_state, rx_next;
    p_state_t          state, next_state;
    logic              rx_meta, rx_sync, rx_prev;
    logic [CW-1:0]     bit_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        rx_byte;
    logic              byte_stb, frame_evt, rx_busy;
    logic [7:0]        cmd_r, len_r, chk_acc, idx;
    logic [7:0]        pbuf [MAX_PARA_BYTES];
    logic [31:0]       to_cnt;
    logic              good_evt, err_evt;
    logic [1:0]        err_cause;

    function automatic logic [7:0] chk_upd(input logic [7:0] acc, input logic [7:0] b);
        return (CHK_MODE == 1) ? (acc ^ b) : (acc + b);
    endfunction

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    // Receiver next state: half-bit start re-check, eight data bits, one stop bit.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
            RX_START: if (bit_cnt == HALF_M1) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_cnt == DIV_M1 && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (bit_cnt == DIV_M1) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Receiver outputs: the byte strobe and framing event coincide with the stop sample.
    always_comb begin
        rx_busy   = (rx_state != RX_IDLE);
        byte_stb  = (rx_state == RX_STOP) && (bit_cnt == DIV_M1) && rx_sync;
        frame_evt = (rx_state == RX_STOP) && (bit_cnt == DIV_M1) && !rx_sync;
    end

    // Receiver bit timer and LSB-first shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            bit_idx <= 3'd0;
            rx_byte <= 8'h00;
        end else begin
            if (rx_state == RX_IDLE || rx_state != rx_next ||
                (rx_state == RX_DATA && bit_cnt == DIV_M1))
                bit_cnt <= '0;
            else
                bit_cnt <= bit_cnt + 1'b1;
            if (rx_state == RX_START) bit_idx <= 3'd0;
            if (rx_state == RX_DATA && bit_cnt == DIV_M1) begin
                rx_byte <= {rx_sync, rx_byte[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // Parser state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Parser next state: any error returns to idle, otherwise advance on each byte.
    always_comb begin
        next_state = state;
        if (err_evt) begin
            next_state = S_IDLE;
        end else if (byte_stb) begin
            case (state)
                S_IDLE:  if (rx_byte == HEADER) next_state = S_CMD;
                S_CMD:   next_state = S_LEN;
                S_LEN:   next_state = (rx_byte == 8'h00) ? S_CHK : S_PARA;
                S_PARA:  if (idx == len_r - 8'd1) next_state = S_CHK;
                S_CHK:   next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Parser events; sources are mutually exclusive, the chain just fixes a cause.
    always_comb begin
        good_evt  = 1'b0;
        err_evt   = 1'b0;
        err_cause = 2'd0;
        if (state != S_IDLE && frame_evt) begin
            err_evt   = 1'b1;
            err_cause = 2'd3;
        end else if (state != S_IDLE && to_cnt == TO_LIMIT) begin
            err_evt   = 1'b1;
            err_cause = 2'd2;
        end else if (byte_stb && state == S_LEN && rx_byte > MAX_B) begin
            err_evt   = 1'b1;
            err_cause = 2'd1;
        end else if (byte_stb && state == S_CHK) begin
            if (rx_byte == chk_acc) begin
                good_evt = 1'b1;
            end else begin
                err_evt   = 1'b1;
                err_cause = 2'd0;
            end
        end
    end

    // Inter-byte timeout counts only line-idle clocks while a frame is open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= 32'd0;
        else if (state == S_IDLE || rx_busy || byte_stb)
            to_cnt <= 32'd0;
        else if (to_cnt != TO_LIMIT)
            to_cnt <= to_cnt + 32'd1;
    end

    // Frame datapath, checksum accumulation and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_r     <= 8'h00;
            len_r     <= 8'h00;
            chk_acc   <= 8'h00;
            idx       <= 8'h00;
            for (int k = 0; k < MAX_PARA_BYTES; k++) pbuf[k] <= 8'h00;
            para_list <= '0;
            cmdcode   <= 8'h00;
            cmd_len   <= 8'h00;
            check     <= 8'h00;
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            cmd_valid <= good_evt;
            cmd_err   <= err_evt;
            if (err_evt) err_code <= err_cause;
            if (byte_stb) begin
                case (state)
                    S_CMD: begin
                        cmd_r   <= rx_byte;
                        chk_acc <= rx_byte;
                    end
                    S_LEN: begin
                        len_r   <= rx_byte;
                        chk_acc <= chk_upd(chk_acc, rx_byte);
                        idx     <= 8'h00;
                    end
                    S_PARA: begin
                        pbuf[idx[IDXW-1:0]] <= rx_byte;
                        idx     <= idx + 8'd1;
                        chk_acc <= chk_upd(chk_acc, rx_byte);
                    end
                    default: ;
                endcase
            end
            if (good_evt) begin
                cmdcode <= cmd_r;
                cmd_len <= len_r;
                check   <= rx_byte;
                for (int k = 0; k < MAX_PARA_BYTES; k++)
                    para_list[8*k +: 8] <= (k < int'(len_r)) ? pbuf[k] : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser_p.sv
// Bench for uart_cmd_parser_p: table of frames, hand-written corner sequences,
// random frames, and a scoreboard matched against every cmd_valid/cmd_err pulse.
module tb_uart_cmd_parser_p;

    // The bit rate is raised so that DIV stays small and the run stays short.
    localparam int CLK_FREQ_HZ = 50_000_000;
    localparam int BAUD        = 3_125_000;
    localparam int DIV         = CLK_FREQ_HZ / BAUD;
    localparam int TO_BITS     = 4;
    localparam int W           = 59;

    logic        clk;
    logic        rst_n;
    logic        uart_rx;
    logic [31:0] para_list;
    logic [7:0]  cmdcode, cmd_len, check;
    logic        cmd_valid, cmd_err;
    logic [1:0]  err_code;

    typedef struct {
        logic [63:0] bytes;
        int          n;
        logic        err;
        logic [1:0]  code;
        logic [7:0]  cmd;
        logic [7:0]  len;
        logic [7:0]  chk;
        logic [31:0] para;
    } vec_t;

    logic [W-1:0] exp_q[$];
    vec_t         tbl[8];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           pulse_cyc = 0;
    logic [7:0]   m_cmd = 8'h00, m_len = 8'h00, m_chk = 8'h00;
    logic [31:0]  m_para = 32'h0;

    uart_cmd_parser_p #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD(BAUD), .MAX_PARA_BYTES(4),
        .HEADER(8'h55), .CHK_MODE(0), .TIMEOUT_BITS(TO_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
        .para_list(para_list), .cmdcode(cmdcode), .cmd_len(cmd_len), .check(check),
        .cmd_valid(cmd_valid), .cmd_err(cmd_err), .err_code(err_code)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic [63:0] b, input int n, input logic e,
                                 input logic [1:0] c, input logic [7:0] cm,
                                 input logic [7:0] ln, input logic [7:0] ck,
                                 input logic [31:0] p);
        vec_t v;
        v.bytes = b; v.n = n; v.err = e; v.code = c;
        v.cmd = cm; v.len = ln; v.chk = ck; v.para = p;
        return v;
    endfunction

    function automatic logic [W-1:0] rec(input logic e, input logic [1:0] c,
                                         input logic [7:0] cm, input logic [7:0] ln,
                                         input logic [7:0] ck, input logic [31:0] p);
        return {e, c, cm, ln, ck, p};
    endfunction

    // Driver: one 8N1 byte, stop level selectable.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = stop;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic push_good(input logic [7:0] cm, input logic [7:0] ln,
                             input logic [7:0] ck, input logic [31:0] p);
        m_cmd = cm; m_len = ln; m_chk = ck; m_para = p;
        exp_q.push_back(rec(1'b0, 2'd0, cm, ln, ck, p));
    endtask

    task automatic push_err(input logic [1:0] c);
        exp_q.push_back(rec(1'b1, c, m_cmd, m_len, m_chk, m_para));
    endtask

    // Bounded wait for the scoreboard to empty, then a quiet window for stray pulses.
    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40 * DIV) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: %0d results still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2 * DIV) @(negedge clk);
    endtask

    task automatic send_rand_frame(input logic corrupt);
        logic [7:0]  cm, ln, acc, ck;
        logic [7:0]  pl [4];
        logic [31:0] p;
        ln = 8'($urandom_range(0, 4));
        cm = 8'($urandom_range(0, 255));
        acc = cm + ln;
        p = 32'h0;
        for (int i = 0; i < 4; i++) begin
            pl[i] = 8'($urandom_range(0, 255));
            if (i < int'(ln)) begin
                acc = acc + pl[i];
                p[8*i +: 8] = pl[i];
            end
        end
        ck = corrupt ? acc + 8'd1 : acc;
        if (corrupt) push_err(2'd0);
        else         push_good(cm, ln, ck, p);
        send_byte(8'h55, 1'b1);
        send_byte(cm, 1'b1);
        send_byte(ln, 1'b1);
        for (int i = 0; i < int'(ln); i++) send_byte(pl[i], 1'b1);
        send_byte(ck, 1'b1);
        wait_drain("rand_frame");
    endtask

    initial begin
        int t0;
        uart_rx = 1'b1;
        rst_n   = 1'b0;

        tbl[0] = mkv(64'h55_01_04_11_22_33_44_AF, 8, 0, 0, 8'h01, 8'h04, 8'hAF, 32'h44332211);
        tbl[1] = mkv(64'h55_01_04_11_22_33_44_AE, 8, 1, 0, 0, 0, 0, 0);
        tbl[2] = mkv(64'h55_03_05_00_00_00_00_00, 3, 1, 1, 0, 0, 0, 0);
        tbl[3] = mkv(64'h55_02_00_02_00_00_00_00, 4, 0, 0, 8'h02, 8'h00, 8'h02, 32'h0);
        tbl[4] = mkv(64'h55_10_01_A5_B6_00_00_00, 5, 0, 0, 8'h10, 8'h01, 8'hB6, 32'h000000A5);
        tbl[5] = mkv(64'h55_07_04_55_55_00_FF_B4, 8, 0, 0, 8'h07, 8'h04, 8'hB4, 32'hFF005555);
        tbl[6] = mkv(64'h00_FF_55_20_02_F0_0F_21, 8, 0, 0, 8'h20, 8'h02, 8'h21, 32'h00000FF0);
        tbl[7] = mkv(64'h55_80_02_40_40_02_00_00, 6, 0, 0, 8'h80, 8'h02, 8'h02, 32'h00004040);

        fork
            // Scoreboard monitor, sampling on the falling edge.
            begin : monitor
                logic [W-1:0] obs, e;
                forever begin
                    @(negedge clk);
                    cyc++;
                    if (cmd_valid || cmd_err) begin
                        pulse_cyc = cyc;
                        obs = {cmd_err, cmd_err ? err_code : 2'd0, cmdcode, cmd_len, check, para_list};
                        n_checks++;
                        if (cmd_valid && cmd_err) begin
                            n_errors++;
                            $display("FAIL both_pulses: cmd_valid=1 cmd_err=1, required one");
                        end else if (exp_q.size() == 0) begin
                            n_errors++;
                            $display("FAIL unexpected_pulse: got %h, required no pulse", obs);
                        end else begin
                            e = exp_q.pop_front();
                            if (obs !== e) begin
                                n_errors++;
                                $display("FAIL frame_result: got %h, expected %h", obs, e);
                            end
                        end
                    end
                end
            end
            begin : watchdog
                #2_000_000;
                $display("FAIL watchdog: simulation did not complete in time");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        repeat (4) @(negedge clk);
        n_checks++;
        if ({para_list, cmdcode, cmd_len, check, cmd_valid, cmd_err, err_code} !== '0) begin
            n_errors++;
            $display("FAIL reset_state: got %h, required 0",
                     {para_list, cmdcode, cmd_len, check, cmd_valid, cmd_err, err_code});
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].err) push_err(tbl[i].code);
            else            push_good(tbl[i].cmd, tbl[i].len, tbl[i].chk, tbl[i].para);
            for (int j = 0; j < tbl[i].n; j++)
                send_byte(tbl[i].bytes[63-8*j -: 8], 1'b1);
            wait_drain("table_frame");
        end

        // Inter-byte timeout, then a good frame is accepted
        push_err(2'd2);
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);
        t0 = cyc;
        wait_drain("timeout");
        n_checks++;
        if (pulse_cyc - t0 < TO_BITS * DIV - DIV / 2 - 4 || pulse_cyc - t0 > TO_BITS * DIV + 4) begin
            n_errors++;
            $display("FAIL timeout_latency: got %0d clk after last stop bit, required about %0d",
                     pulse_cyc - t0, TO_BITS * DIV - DIV / 2);
        end
        push_good(8'h01, 8'h04, 8'hAF, 32'h44332211);
        for (int j = 0; j < 8; j++) send_byte(tbl[0].bytes[63-8*j -: 8], 1'b1);
        wait_drain("after_timeout");

        // Framing error inside a frame; a bad stop bit while idle is silent
        push_err(2'd3);
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h04, 1'b0);
        wait_drain("framing");
        send_byte(8'h3C, 1'b0);
        wait_drain("idle_framing");

        // Reset mid-payload clears everything without pulses
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h11, 1'b1);
        repeat (DIV / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({para_list, cmdcode, cmd_len, check, cmd_valid, cmd_err, err_code} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_frame: got %h, required 0",
                     {para_list, cmdcode, cmd_len, check, cmd_valid, cmd_err, err_code});
        end
        rst_n = 1'b1;
        m_cmd = 8'h00; m_len = 8'h00; m_chk = 8'h00; m_para = 32'h0;
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        wait_drain("post_reset_idle");
        n_checks++;
        if ({para_list, cmdcode, cmd_len, check} !== '0) begin
            n_errors++;
            $display("FAIL post_reset_hold: got %h, required 0",
                     {para_list, cmdcode, cmd_len, check});
        end

        // Junk bytes while idle
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_drain("junk_idle");

        // Random frames, some with a corrupted checksum
        for (int r = 0; r < 6; r++) send_rand_frame(r % 3 == 2);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL leftover_expected: got %0d pending, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
